// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the UART transmitter: parity-mode codes,
//               FSM state encoding and a small parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Parity-mode codes on the parity_mode input (2'b11 also means "none")
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Transmitter FSM state encoding
  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_PARITY = 3'd3;
  localparam logic [2:0] c_ST_STOP   = 3'd4;

  // True when the mode inserts a parity bit into the frame
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_if
// Description : Write-side bus of the UART transmitter: write strobe and data,
//               overflow clear, and the FIFO status returned to the writer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
);

  logic                          wr_en;
  logic [DATA_W-1:0]             wr_data;
  logic                          ovf_clr;
  logic                          full;
  logic                          empty;
  logic [$clog2(FIFO_DEPTH):0]   count;
  logic                          overflow;

  // Producer side (writes words, reads status)
  modport master (
    output wr_en, wr_data, ovf_clr,
    input  full, empty, count, overflow
  );

  // Transmitter side (accepts words, reports status)
  modport slave (
    input  wr_en, wr_data, ovf_clr,
    output full, empty, count, overflow
  );

endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO with registered full/empty/count. Writes
//               while full are ignored even if a read happens the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  wire logic                        clk,
  input  wire logic                        rst,
  input  wire logic                        wr_en,
  input  wire logic [WIDTH-1:0]            wr_data,
  input  wire logic                        rd_en,
  output logic [WIDTH-1:0]                 rd_data,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH):0]           count
);

  localparam int              c_AW    = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_DEPTH = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic [c_AW:0]    w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  assign w_push = wr_en && !r_full;
  assign w_pop  = rd_en && !r_empty;

  // Next occupancy; simultaneous push and pop leave it unchanged
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Pointers and status flags; pointers wrap naturally since DEPTH is 2^n
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_DEPTH);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage array; contents need no reset since empty hides stale words
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = r_full;
  assign empty   = r_empty;
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter fed by a FIFO. Frame = start, DATA_W data
//               bits LSB first, optional parity, one or two stop bits. Line
//               settings are captured when each frame starts.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [DIV_W-1:0]  baud_div,
  input  wire logic [1:0]        parity_mode,
  input  wire logic              stop2,
  uart_tx_fifo_if.slave          wr_if,
  output logic                   tx,
  output logic                   busy
);

  localparam int                 c_BIT_W    = $clog2(DATA_W);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_W - 1);

  logic [2:0]                    r_state;
  logic [DIV_W-1:0]              r_div;
  logic [DIV_W-1:0]              r_baud_cnt;
  logic [DATA_W-1:0]             r_shift;
  logic [c_BIT_W-1:0]            r_bit_cnt;
  logic                          r_par_en;
  logic                          r_par_bit;
  logic                          r_stop2;
  logic                          r_stop_cnt;
  logic                          r_tx;
  logic                          r_ovf;

  logic                          w_pop;
  logic                          w_bit_end;
  logic [DATA_W-1:0]             w_rd_data;
  logic                          w_full;
  logic                          w_empty;
  logic [$clog2(FIFO_DEPTH):0]   w_count;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_if.wr_en),
    .wr_data (wr_if.wr_data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  // A word leaves the FIFO on the same edge the start bit begins
  assign w_pop     = (r_state == c_ST_IDLE) && !w_empty;
  assign w_bit_end = (r_baud_cnt == r_div);

  // Baud counter: cleared at frame start so the start bit is full length
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud_cnt <= '0;
    end else if (w_pop || (r_state == c_ST_IDLE) || w_bit_end) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

  // Frame sequencer: shifts data out and drives the registered tx line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_ST_IDLE;
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_div      <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (!w_empty) begin
            r_state    <= c_ST_START;
            r_tx       <= 1'b0;
            r_shift    <= w_rd_data;
            r_div      <= baud_div;
            r_par_en   <= par_enabled(parity_mode);
            r_par_bit  <= (^w_rd_data) ^ (parity_mode == PAR_ODD);
            r_stop2    <= stop2;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
          end
        end
        c_ST_START: begin
          if (w_bit_end) begin
            r_state   <= c_ST_DATA;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
          end
        end
        c_ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == c_LAST_BIT) begin
              if (r_par_en) begin
                r_state <= c_ST_PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state <= c_ST_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        c_ST_PARITY: begin
          if (w_bit_end) begin
            r_state <= c_ST_STOP;
            r_tx    <= 1'b1;
          end
        end
        c_ST_STOP: begin
          if (w_bit_end) begin
            if (r_stop2 && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
            end else begin
              r_state <= c_ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  // Sticky overflow: a dropped write wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (wr_if.wr_en && w_full) begin
      r_ovf <= 1'b1;
    end else if (wr_if.ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign tx             = r_tx;
  assign busy           = (r_state != c_ST_IDLE);
  assign wr_if.full     = w_full;
  assign wr_if.empty    = w_empty;
  assign wr_if.count    = w_count;
  assign wr_if.overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. A queue-based line model
//               predicts tx, busy and FIFO status every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int c_FD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        tx;
  logic        busy;

  uart_tx_fifo_if #(.DATA_W(8), .FIFO_DEPTH(c_FD)) bus ();

  uart_tx_fifo #(
    .DATA_W     (8),
    .FIFO_DEPTH (c_FD),
    .DIV_W      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .wr_if       (bus),
    .tx          (tx),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, the line as a queue of per-cycle levels
  logic [7:0] fq[$];
  bit         wave[$];
  bit         m_ovf = 1'b0;
  bit         m_drop;

  function automatic void build_frame(input logic [7:0] d, input int div,
                                      input logic [1:0] pm, input bit s2);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pm == 2'b01) bits.push_back(^d);
    else if (pm == 2'b10) bits.push_back(~^d);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k <= div; k++) wave.push_back(bits[i]);
  endfunction

  function automatic logic m_tx();
    return (wave.size() != 0) ? wave[0] : 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fq.delete();
      wave.delete();
      m_ovf = 1'b0;
    end else begin
      m_drop = bus.wr_en && (fq.size() == c_FD);
      if (wave.size() != 0) void'(wave.pop_front());
      else if (fq.size() != 0)
        build_frame(fq.pop_front(), int'(baud_div), parity_mode, stop2);
      if (bus.wr_en && !m_drop) fq.push_back(bus.wr_data);
      if (m_drop) m_ovf = 1'b1;
      else if (bus.ovf_clr) m_ovf = 1'b0;
    end
  end

  // Per-cycle comparison, half a period away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx",       32'(tx),           32'(m_tx()));
      chk("busy",     32'(busy),         32'(wave.size() != 0));
      chk("count",    32'(bus.count),    32'(fq.size()));
      chk("full",     32'(bus.full),     32'(fq.size() == c_FD));
      chk("empty",    32'(bus.empty),    32'(fq.size() == 0));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    end
  end

  // Observation counters for busy time and frame starts
  int busy_cyc = 0;
  int starts   = 0;
  bit prev_busy = 1'b0;
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cyc++;
    if (busy === 1'b1 && !prev_busy) starts++;
    prev_busy = (busy === 1'b1);
  end

  task automatic write_word(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy && bus.empty) break;
    end
    chk("idle_busy",  32'(busy),      32'd0);
    chk("idle_empty", 32'(bus.empty), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus.wr_en = 1'b0; bus.wr_data = '0; bus.ovf_clr = 1'b0;
    baud_div = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    #3 rst = 1'b0;
    @(negedge clk);
    chk("rst_tx",    32'(tx),           32'd1);
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_count", 32'(bus.count),    32'd0);
    chk("rst_empty", 32'(bus.empty),    32'd1);
    chk("rst_full",  32'(bus.full),     32'd0);
    chk("rst_ovf",   32'(bus.overflow), 32'd0);
    chk_en = 1'b1;
    @(negedge clk); #2 rst = 1'b1;
    repeat (3) @(negedge clk);

    // Scenario 1: 0x4D, 4-cycle bits, no parity, one stop bit
    busy_cyc = 0;
    write_word(8'h4D);
    wait_idle(200);
    chk("s1_busy_cycles", 32'(busy_cyc), 32'd40);

    // Scenario 2: even then odd parity on 0xB3
    parity_mode = 2'b01;
    write_word(8'hB3);
    wait_idle(200);
    parity_mode = 2'b10;
    write_word(8'hB3);
    wait_idle(200);

    // Scenario 3: two stop bits, back-to-back frames
    parity_mode = 2'b00; stop2 = 1'b1;
    write_word(8'h5A);
    write_word(8'hC3);
    wait_idle(300);
    stop2 = 1'b0;

    // Scenario 4: six writes into a 4-deep FIFO
    baud_div = 16'd9; starts = 0;
    for (int i = 0; i < 6; i++) write_word(8'(8'h10 + i));
    chk("s4_full",     32'(bus.full),     32'd1);
    chk("s4_overflow", 32'(bus.overflow), 32'd1);
    wait_idle(800);
    chk("s4_frames", 32'(starts), 32'd5);
    bus.ovf_clr = 1'b1; @(negedge clk); bus.ovf_clr = 1'b0;
    @(negedge clk);

    // Scenario 5: reset during the third data bit with three words queued
    baud_div = 16'd3;
    for (int i = 0; i < 4; i++) write_word(8'(8'hE0 + i));
    chk("s5_count_before", 32'(bus.count), 32'd3);
    repeat (11) @(negedge clk);
    chk("s5_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("s5_tx",    32'(tx),        32'd1);
    chk("s5_busy",  32'(busy),      32'd0);
    chk("s5_count", 32'(bus.count), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    starts = 0;
    repeat (60) @(negedge clk);
    chk("s5_no_frame", 32'(starts), 32'd0);

    // Scenario 6: divisor change mid-frame only affects the next frame
    baud_div = 16'd3;
    write_word(8'hA5);
    repeat (10) @(negedge clk);
    baud_div = 16'd7;
    write_word(8'h3C);
    wait_idle(400);

    // Randomized traffic with mid-stream setting changes and resets
    for (int c = 0; c < 2500; c++) begin
      bus.wr_en   = ($urandom_range(0, 5) == 0);
      bus.wr_data = 8'($urandom);
      bus.ovf_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 30) == 0) baud_div    = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 30) == 0) parity_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 30) == 0) stop2       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 400) == 0) begin
        #2 rst = 1'b0;
        #2 rst = 1'b1;
      end
      @(negedge clk);
    end
    bus.wr_en = 1'b0; bus.ovf_clr = 1'b0;
    wait_idle(2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
